// File: rtl/sw_input_port_pkg.sv
// Shared constants and encodings for the switch input port and its debouncer.
package sw_input_port_pkg;

    localparam int unsigned DB_CNT_DEFAULT = 1000000;
    localparam int unsigned RD_W           = 32;

    typedef enum logic {
        SEL_LEVEL = 1'b0,
        SEL_EVENT = 1'b1
    } sel_e;

endpackage

// File: rtl/sw_input_port_debounce_bit.sv
// One switch bit: 2-FF synchroniser, persistence counter and accepted level.
module sw_debounce_bit
    import sw_input_port_pkg::*;
#(
    parameter int unsigned DB_CNT = DB_CNT_DEFAULT,
    parameter int unsigned CNT_W  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out,
    output logic change_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             change;

    always_comb begin
        s1_d     = raw_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        change   = 1'b0;
        // Any sample matching the accepted level restarts the persistence count.
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                change   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;
    assign change_out = change;

endmodule

// File: rtl/sw_input_port.sv
// Debounced switch input port: sticky per-bit change events and a registered,
// read-to-clear CPU read port selecting level or event view.
module sw_input_port
    import sw_input_port_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DB_CNT = DB_CNT_DEFAULT,
    parameter int unsigned CNT_W  = 20
) (
    input  logic             clkIn,
    input  logic             resetIn,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             ReadIn,
    input  logic             SelIn,
    output logic [RD_W-1:0]  DataOut,
    output logic             EventOut
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] change;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        sw_debounce_bit #(
            .DB_CNT (DB_CNT),
            .CNT_W  (CNT_W)
        ) u_db (
            .clk        (clkIn),
            .rst        (resetIn),
            .raw_in     (sw_raw[i]),
            .stable_out (stable[i]),
            .change_out (change[i])
        );
    end

    logic [WIDTH-1:0] event_q, event_d;
    logic [RD_W-1:0]  data_q, data_d;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] clr_mask;
    sel_e             sel;

    always_comb begin
        sel      = sel_e'(SelIn);
        rd_word  = (sel == SEL_EVENT) ? event_q : stable;
        data_d   = data_q;
        clr_mask = '0;
        if (ReadIn) begin
            data_d = RD_W'(rd_word);
            if (sel == SEL_EVENT) begin
                clr_mask = event_q;
            end
        end
        // A change landing on the clearing edge survives: set wins over clear.
        event_d = (event_q & ~clr_mask) | change;
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            event_q <= '0;
            data_q  <= '0;
        end else begin
            event_q <= event_d;
            data_q  <= data_d;
        end
    end

    assign DataOut  = data_q;
    assign EventOut = |event_q;

endmodule

// File: tb/tb_sw_input_port.sv
// Directed table-driven bench for sw_input_port with DB_CNT=4, WIDTH=16, CNT_W=3.
module tb_sw_input_port;

    logic        clkIn   = 1'b0;
    logic        resetIn = 1'b1;
    logic [15:0] sw_raw  = 16'h0000;
    logic        ReadIn  = 1'b0;
    logic        SelIn   = 1'b0;
    logic [31:0] DataOut;
    logic        EventOut;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    sw_input_port #(
        .WIDTH  (16),
        .DB_CNT (4),
        .CNT_W  (3)
    ) dut (
        .clkIn    (clkIn),
        .resetIn  (resetIn),
        .sw_raw   (sw_raw),
        .ReadIn   (ReadIn),
        .SelIn    (SelIn),
        .DataOut  (DataOut),
        .EventOut (EventOut)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic        rst;
        logic [15:0] raw;
        logic        rd;
        logic        sel;
        logic [31:0] exp_data;
        logic        exp_evt;
    } vec_t;

    vec_t vec[$];

    task automatic add(input logic rst, input logic [15:0] raw, input logic rd,
                       input logic sel, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.rst = rst; v.raw = raw; v.rd = rd; v.sel = sel;
        v.exp_data = ed; v.exp_evt = ee;
        vec.push_back(v);
    endtask

    task automatic step();
        @(posedge clkIn);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int unsigned lat;
        bit          found;

        // reset with all switches high, then level read right after reset
        add(1, 16'hFFFF, 0, 0, 32'h0, 0);
        add(1, 16'hFFFF, 0, 0, 32'h0, 0);
        add(0, 16'h0000, 1, 0, 32'h0, 0);
        add(0, 16'h0000, 0, 0, 32'h0, 0);
        // bit 3 rises: stable/event on edge 6 of the new level
        for (int i = 0; i < 4; i++) add(0, 16'h0008, 0, 0, 32'h0, 0);
        add(0, 16'h0008, 1, 0, 32'h0, 0);
        add(0, 16'h0008, 1, 0, 32'h0, 1);
        add(0, 16'h0008, 1, 0, 32'h8, 1);
        // event read clears, second read empty
        add(0, 16'h0008, 1, 1, 32'h8, 0);
        add(0, 16'h0008, 1, 1, 32'h0, 0);
        // 3-cycle glitch on bit 0 is rejected
        for (int i = 0; i < 3; i++) add(0, 16'h0009, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) add(0, 16'h0008, 0, 0, 32'h0, 0);
        add(0, 16'h0008, 1, 0, 32'h8, 0);
        add(0, 16'h0008, 1, 1, 32'h0, 0);
        // bit 3 falls (pending), bit 5 qualifies on the clearing read edge
        add(0, 16'h0000, 0, 0, 32'h0, 0);
        add(0, 16'h0000, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) add(0, 16'h0020, 0, 0, 32'h0, 0);
        add(0, 16'h0020, 0, 0, 32'h0, 1);
        add(0, 16'h0020, 0, 0, 32'h0, 1);
        add(0, 16'h0020, 1, 1, 32'h8, 1);
        add(0, 16'h0020, 1, 1, 32'h20, 0);
        add(0, 16'h0020, 1, 0, 32'h20, 0);
        // reset, then bit 7 rises and reset hits at cnt=2
        add(1, 16'h0000, 0, 0, 32'h0, 0);
        add(0, 16'h0000, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) add(0, 16'h0080, 0, 0, 32'h0, 0);
        add(1, 16'h0080, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) add(0, 16'h0080, 0, 0, 32'h0, 0);
        add(0, 16'h0080, 1, 1, 32'h0, 0);
        add(0, 16'h0080, 1, 0, 32'h0, 1);
        add(0, 16'h0080, 1, 0, 32'h80, 1);
        add(0, 16'h0080, 1, 1, 32'h80, 0);
        add(0, 16'h0080, 0, 0, 32'h80, 0);

        foreach (vec[i]) begin
            resetIn = vec[i].rst;
            sw_raw  = vec[i].raw;
            ReadIn  = vec[i].rd;
            SelIn   = vec[i].sel;
            step();
            check($sformatf("row%0d data", i), DataOut, vec[i].exp_data);
            check($sformatf("row%0d event", i), {31'b0, EventOut}, {31'b0, vec[i].exp_evt});
        end

        // exactly DB_CNT-cycle pulse on bit 9 is accepted, then its fall too
        resetIn = 1'b0;
        ReadIn  = 1'b0;
        sw_raw  = 16'h0280;
        found   = 1'b0;
        lat     = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            if (c == 5) sw_raw = 16'h0080;
            step();
            if (EventOut) begin
                found = 1'b1;
                lat   = c;
            end
        end
        check("pulse4 rise latency", lat, 6);

        ReadIn = 1'b1; SelIn = 1'b1;
        step();
        ReadIn = 1'b0;
        check("pulse4 rise event", DataOut, 32'h200);
        check("pulse4 cleared", {31'b0, EventOut}, 32'h0);

        found = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (EventOut) begin
                found = 1'b1;
                lat   = c;
            end
        end
        check("pulse4 fall latency", lat, 3);

        ReadIn = 1'b1; SelIn = 1'b0;
        step();
        check("pulse4 level", DataOut, 32'h80);
        SelIn = 1'b1;
        step();
        check("pulse4 fall event", DataOut, 32'h200);
        ReadIn = 1'b0;
        step();
        step();
        check("read data hold", DataOut, 32'h200);
        check("events idle", {31'b0, EventOut}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
